// File: rtl/bcd_updown_counter_if.sv
// Control and status bundle for bcd_updown_counter. The master drives the step and load
// controls, and the slave (the counter) returns the registered count and terminal-count pulse.
interface bcd_updown_counter_if #(
  parameter int N = 16
);
  logic         enable;
  logic         up;
  logic         load;
  logic [N-1:0] load_value;
  logic         bcd_mode;
  logic [N-1:0] modulo;
  logic [N-1:0] count;
  logic         tc;

  modport master (
    output enable, up, load, load_value, bcd_mode, modulo,
    input  count, tc
  );

  modport slave (
    input  enable, up, load, load_value, bcd_mode, modulo,
    output count, tc
  );
endinterface

// File: rtl/bcd_updown_counter.sv
// Up/down counter with binary modulus or runtime BCD mode, synchronous load and registered tc.
// One step per enabled edge. Load beats step. Count and tc update on the edge that samples them.
module bcd_updown_counter #(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                reset,
  bcd_updown_counter_if.slave bus
);
  localparam int           D    = N / 4;
  localparam logic [N-1:0] ONE  = N'(1);
  localparam logic [N-1:0] ALL1 = {N{1'b1}};

  typedef struct packed {
    logic [N-1:0] val;
    logic         wrap;
  } step_t;

  logic [N-1:0] count_q, count_d;
  logic         tc_q, tc_d;

  function automatic logic [N-1:0] bcd_clamp(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = v;
    for (int k = 0; k < D; k++) begin
      if (v[4*k +: 4] > 4'd9) r[4*k +: 4] = 4'd9;
    end
    return r;
  endfunction

  // v must already be clamped. The carry or borrow surviving past the top digit is the wrap.
  function automatic step_t bcd_step(input logic [N-1:0] v, input logic up);
    step_t r;
    logic  cy;
    r.val = v;
    cy    = 1'b1;
    for (int k = 0; k < D; k++) begin
      if (cy) begin
        if (up) begin
          if (v[4*k +: 4] == 4'd9) begin
            r.val[4*k +: 4] = 4'd0;
          end else begin
            r.val[4*k +: 4] = v[4*k +: 4] + 4'd1;
            cy              = 1'b0;
          end
        end else begin
          if (v[4*k +: 4] == 4'd0) begin
            r.val[4*k +: 4] = 4'd9;
          end else begin
            r.val[4*k +: 4] = v[4*k +: 4] - 4'd1;
            cy              = 1'b0;
          end
        end
      end
    end
    r.wrap = cy;
    return r;
  endfunction

  // m == 0 selects the full 2^N range. A count stranded at or above a lowered modulus
  // re-enters the range: upward as a wrap to 0, downward to the top without a wrap.
  function automatic step_t bin_step(input logic [N-1:0] v, input logic [N-1:0] m,
                                     input logic up);
    step_t        r;
    logic         full;
    logic [N-1:0] top;
    full   = (m == '0);
    top    = full ? ALL1 : m - ONE;
    r.val  = v;
    r.wrap = 1'b0;
    if (!full && v >= m) begin
      r.val  = up ? '0 : top;
      r.wrap = up;
    end else if (up) begin
      if (v == top) begin
        r.val  = '0;
        r.wrap = 1'b1;
      end else begin
        r.val = v + ONE;
      end
    end else begin
      if (v == '0) begin
        r.val  = top;
        r.wrap = 1'b1;
      end else begin
        r.val = v - ONE;
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] load_fix(input logic [N-1:0] lv, input logic [N-1:0] m,
                                            input logic bcd);
    logic [N-1:0] r;
    if (bcd) begin
      r = bcd_clamp(lv);
    end else if (m != '0 && lv >= m) begin
      r = m - ONE;
    end else begin
      r = lv;
    end
    return r;
  endfunction

  step_t step;

  always_comb begin
    step = bus.bcd_mode ? bcd_step(bcd_clamp(count_q), bus.up)
                        : bin_step(count_q, bus.modulo, bus.up);
  end

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      count_d = load_fix(bus.load_value, bus.modulo, bus.bcd_mode);
    end else if (bus.enable) begin
      count_d = step.val;
      tc_d    = step.wrap;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: a vector table on a 16-bit instance, hand-written
// sequences for reset, hold, and 8-bit full-range rollover.
module tb_bcd_updown_counter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  bcd_updown_counter_if #(.N(16)) ifa ();
  bcd_updown_counter_if #(.N(8))  ifb ();

  bcd_updown_counter #(.N(16)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  bcd_updown_counter #(.N(8))  dut_b (.clk(clk), .reset(reset), .bus(ifb));

  typedef struct {
    string       name;
    logic        ld;
    logic        en;
    logic        upv;
    logic        bcd;
    logic [15:0] lv;
    logic [15:0] mod;
    logic [15:0] exp_count;
    logic        exp_tc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic ld, logic en, logic upv, logic bcd,
                              logic [15:0] lv, logic [15:0] mod,
                              logic [15:0] exp_count, logic exp_tc);
    vec_t v;
    v.name = name; v.ld = ld; v.en = en; v.upv = upv; v.bcd = bcd;
    v.lv = lv; v.mod = mod; v.exp_count = exp_count; v.exp_tc = exp_tc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic ld, input logic en, input logic upv, input logic bcd,
                         input logic [15:0] lv, input logic [15:0] mod);
    ifa.load = ld; ifa.enable = en; ifa.up = upv; ifa.bcd_mode = bcd;
    ifa.load_value = lv; ifa.modulo = mod;
  endtask

  initial begin
    drive_a(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    ifb.load = 1'b0; ifb.enable = 1'b0; ifb.up = 1'b1; ifb.bcd_mode = 1'b0;
    ifb.load_value = 8'h00; ifb.modulo = 8'h00;

    // binary modulo
    vecs.push_back(mk("mod_load7",    1, 0, 1, 0, 16'd7,  16'd10, 16'd8 - 16'd1, 0));
    vecs.push_back(mk("mod_up8",      0, 1, 1, 0, 16'd0,  16'd10, 16'd8, 0));
    vecs.push_back(mk("mod_up9",      0, 1, 1, 0, 16'd0,  16'd10, 16'd9, 0));
    vecs.push_back(mk("mod_wrap0",    0, 1, 1, 0, 16'd0,  16'd10, 16'd0, 1));
    vecs.push_back(mk("hold_tc_clr",  0, 0, 1, 0, 16'd0,  16'd10, 16'd0, 0));
    vecs.push_back(mk("mod_down_wr",  0, 1, 0, 0, 16'd0,  16'd10, 16'd9, 1));
    vecs.push_back(mk("mod_down8",    0, 1, 0, 0, 16'd0,  16'd10, 16'd8, 0));
    vecs.push_back(mk("mod_load15",   1, 0, 1, 0, 16'd15, 16'd10, 16'd9, 0));
    // out-of-range after lowering modulus
    vecs.push_back(mk("oor_load8",    1, 0, 1, 0, 16'd8,  16'd10, 16'd8, 0));
    vecs.push_back(mk("oor_up",       0, 1, 1, 0, 16'd0,  16'd5,  16'd0, 1));
    vecs.push_back(mk("oor_load7",    1, 0, 1, 0, 16'd7,  16'd10, 16'd7, 0));
    vecs.push_back(mk("oor_down",     0, 1, 0, 0, 16'd0,  16'd5,  16'd4, 0));
    vecs.push_back(mk("rev_up_wrap",  0, 1, 1, 0, 16'd0,  16'd5,  16'd0, 1));
    vecs.push_back(mk("rev_down_wr",  0, 1, 0, 0, 16'd0,  16'd5,  16'd4, 1));
    // BCD
    vecs.push_back(mk("bcd_ld0999",   1, 0, 1, 1, 16'h0999, 16'h0, 16'h0999, 0));
    vecs.push_back(mk("bcd_carry",    0, 1, 1, 1, 16'h0000, 16'h0, 16'h1000, 0));
    vecs.push_back(mk("bcd_ld9999",   1, 0, 1, 1, 16'h9999, 16'h0, 16'h9999, 0));
    vecs.push_back(mk("bcd_wrap_up",  0, 1, 1, 1, 16'h0000, 16'h0, 16'h0000, 1));
    vecs.push_back(mk("bcd_wrap_dn",  0, 1, 0, 1, 16'h0000, 16'h0, 16'h9999, 1));
    vecs.push_back(mk("bcd_down",     0, 1, 0, 1, 16'h0000, 16'h0, 16'h9998, 0));
    vecs.push_back(mk("bcd_clamp",    1, 0, 1, 1, 16'h3A7F, 16'h0, 16'h3979, 0));
    vecs.push_back(mk("bcd_clamp_up", 0, 1, 1, 1, 16'h0000, 16'h0, 16'h3980, 0));
    vecs.push_back(mk("bin_ld00FA",   1, 0, 1, 0, 16'h00FA, 16'h0, 16'h00FA, 0));
    vecs.push_back(mk("mode_sw_up",   0, 1, 1, 1, 16'h0000, 16'h0, 16'h0100, 0));
    // load beats a step that would have wrapped
    vecs.push_back(mk("pri_ld9999",   1, 0, 1, 1, 16'h9999, 16'h0, 16'h9999, 0));
    vecs.push_back(mk("pri_ld_en",    1, 1, 1, 1, 16'h0042, 16'h0, 16'h0042, 0));
    // binary full range 16-bit
    vecs.push_back(mk("full_ldFFFF",  1, 0, 1, 0, 16'hFFFF, 16'h0, 16'hFFFF, 0));
    vecs.push_back(mk("full_wrap_up", 0, 1, 1, 0, 16'h0000, 16'h0, 16'h0000, 1));
    vecs.push_back(mk("full_wrap_dn", 0, 1, 0, 0, 16'h0000, 16'h0, 16'hFFFF, 1));
    vecs[0].exp_count = 16'd7;

    // reset, with a pending load that must be discarded
    tick();
    chk("rst_count", ifa.count, 16'h0000);
    chk("rst_tc", {15'd0, ifa.tc}, 16'h0000);
    reset = 1'b0;
    drive_a(1'b1, 1'b0, 1'b1, 0, 16'h1234, 16'h0);
    tick();
    chk("pre_ld1234", ifa.count, 16'h1234);
    ifa.load = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_rst_count", ifa.count, 16'h0000);
    chk("async_rst_tc", {15'd0, ifa.tc}, 16'h0000);
    drive_a(1'b1, 1'b1, 1'b1, 1'b0, 16'h5555, 16'h0);
    tick();
    chk("rst_drop_load", ifa.count, 16'h0000);
    drive_a(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0);
    reset = 1'b0;
    tick();
    chk("first_step", ifa.count, 16'h0001);
    chk("first_step_tc", {15'd0, ifa.tc}, 16'h0000);

    foreach (vecs[i]) begin
      drive_a(vecs[i].ld, vecs[i].en, vecs[i].upv, vecs[i].bcd, vecs[i].lv, vecs[i].mod);
      tick();
      chk({vecs[i].name, "_count"}, ifa.count, vecs[i].exp_count);
      chk({vecs[i].name, "_tc"}, {15'd0, ifa.tc}, {15'd0, vecs[i].exp_tc});
    end

    // hold: control changes while disabled must not matter
    drive_a(1'b1, 1'b1, 1'b1, 1'b0, 16'h0042, 16'h0);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive_a(1'b0, 1'b0, c[0], c[1], 16'h7777, 16'(c + 3));
      tick();
      chk("hold_count", ifa.count, 16'h0042);
      chk("hold_tc", {15'd0, ifa.tc}, 16'h0000);
    end

    // 8-bit full-range rollover
    ifb.load = 1'b1; ifb.load_value = 8'hFE; ifb.up = 1'b1;
    tick();
    chk("n8_ldFE", {8'd0, ifb.count}, 16'h00FE);
    ifb.load = 1'b0; ifb.enable = 1'b1;
    tick();
    chk("n8_FF", {8'd0, ifb.count}, 16'h00FF);
    chk("n8_FF_tc", {15'd0, ifb.tc}, 16'h0000);
    tick();
    chk("n8_00", {8'd0, ifb.count}, 16'h0000);
    chk("n8_00_tc", {15'd0, ifb.tc}, 16'h0001);
    tick();
    chk("n8_01", {8'd0, ifb.count}, 16'h0001);
    chk("n8_01_tc", {15'd0, ifb.tc}, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
